// File: rtl/mul3_pkg.sv
// Shared widths, state encoding and count-width helper for the mul3 MAC stage.
package mul3_pkg;

  localparam int PROD_W = 6;
  localparam int OPND_W = 3;

  typedef enum logic {ACCUM, HOLD} mac_state_t;

  // Term counter width; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul3.sv
// Existing 3x3 unsigned combinational multiplier, bit-level ports a0..a2, b0..b2, z0..z5.
module mul3 (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  output logic z0,
  output logic z1,
  output logic z2,
  output logic z3,
  output logic z4,
  output logic z5
);

  logic [5:0] a_ext;
  logic [5:0] b_ext;
  logic [5:0] prod;

  assign a_ext = {3'b000, a2, a1, a0};
  assign b_ext = {3'b000, b2, b1, b0};
  assign prod  = a_ext * b_ext;

  assign {z5, z4, z3, z2, z1, z0} = prod;

endmodule

// File: rtl/mul3_mac.sv
// Multiply-accumulate stage: sums TERMS mul3 products per output word over valid/ready.
// Build option: define MUL3_MAC_SAT_EN for saturating accumulation (default wraps).
module mul3_mac
  import mul3_pkg::*;
#(
  parameter int TERMS = 4,
  parameter int ACC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = cnt_w(TERMS);
  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

  mac_state_t        state_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [ACC_W-1:0]  out_sum_q;
  logic              out_ovf_q;

  logic [PROD_W-1:0] p;
  logic [SUM_W-1:0]  sum_w;
  logic              carry;

  mul3 u_mul3 (
    .a0(in_a[0]), .a1(in_a[1]), .a2(in_a[2]),
    .b0(in_b[0]), .b1(in_b[1]), .b2(in_b[2]),
    .z0(p[0]), .z1(p[1]), .z2(p[2]), .z3(p[3]), .z4(p[4]), .z5(p[5])
  );

  assign sum_w = {1'b0, acc_q} + SUM_W'(p);
  assign carry = sum_w[ACC_W];
  assign ovf_d = ovf_q | carry;
  assign cnt_d = cnt_q + 1'b1;

`ifdef MUL3_MAC_SAT_EN
  // Once clamped the accumulator is pinned at full scale for the rest of the word.
  assign acc_d = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign acc_d = sum_w[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end else if (in_valid && in_ready_q) begin
            if (cnt_q == LAST_CNT) begin
              out_sum_q   <= acc_d;
              out_ovf_q   <= ovf_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              in_ready_q  <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end
        end
        HOLD: begin
          // clear is deliberately ignored here so a finished word is never dropped.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q    <= ACCUM;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mul3_mac.sv
// Scoreboard bench for mul3_mac: a TERMS=4 instance for the main tests, TERMS=8 for overflow.
module tb_mul3_mac;

  typedef struct packed {
    logic [7:0] sum;
    logic       ovf;
  } exp_t;

`ifdef MUL3_MAC_SAT_EN
  localparam logic [7:0] OVF_SUM = 8'd255;
`else
  localparam logic [7:0] OVF_SUM = 8'd136;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       v4_valid = 1'b0, v4_ready, v4_clear = 1'b0, o4_valid, o4_ready = 1'b1, o4_ovf;
  logic [2:0] v4_a = '0, v4_b = '0;
  logic [7:0] o4_sum;

  logic       v8_valid = 1'b0, v8_ready, v8_clear = 1'b0, o8_valid, o8_ready = 1'b1, o8_ovf;
  logic [2:0] v8_a = '0, v8_b = '0;
  logic [7:0] o8_sum;

  exp_t q4[$];
  exp_t q8[$];
  int   vectors = 0;
  int   fails   = 0;

  always #5 clk = ~clk;

  mul3_mac #(.TERMS(4), .ACC_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4_valid), .in_ready(v4_ready),
    .in_a(v4_a), .in_b(v4_b), .clear(v4_clear), .out_valid(o4_valid),
    .out_ready(o4_ready), .out_sum(o4_sum), .out_ovf(o4_ovf)
  );

  mul3_mac #(.TERMS(8), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8_valid), .in_ready(v8_ready),
    .in_a(v8_a), .in_b(v8_b), .clear(v8_clear), .out_valid(o8_valid),
    .out_ready(o8_ready), .out_sum(o8_sum), .out_ovf(o8_ovf)
  );

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o4_valid && o4_ready) begin
      vectors++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL word4_unexpected got sum=%0d ovf=%0d, no word expected", o4_sum, o4_ovf);
      end else begin
        e = q4.pop_front();
        if (o4_sum !== e.sum || o4_ovf !== e.ovf) begin
          fails++;
          $display("FAIL word4 got sum=%0d ovf=%0d, expected sum=%0d ovf=%0d",
                   o4_sum, o4_ovf, e.sum, e.ovf);
        end
      end
    end
    if (!rst && o8_valid && o8_ready) begin
      vectors++;
      if (q8.size() == 0) begin
        fails++;
        $display("FAIL word8_unexpected got sum=%0d ovf=%0d, no word expected", o8_sum, o8_ovf);
      end else begin
        e = q8.pop_front();
        if (o8_sum !== e.sum || o8_ovf !== e.ovf) begin
          fails++;
          $display("FAIL word8 got sum=%0d ovf=%0d, expected sum=%0d ovf=%0d",
                   o8_sum, o8_ovf, e.sum, e.ovf);
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one operand pair and hold it until the selected DUT accepts it.
  task automatic send(input bit sel, input int a, input int b);
    bit acc = 1'b0;
    int n   = 0;
    if (sel) begin v8_valid = 1'b1; v8_a = 3'(a); v8_b = 3'(b); end
    else     begin v4_valid = 1'b1; v4_a = 3'(a); v4_b = 3'(b); end
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = sel ? v8_ready : v4_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      vectors++;
      fails++;
      $display("FAIL send_timeout dut=%0d pair=(%0d,%0d) not accepted in %0d cycles", sel, a, b, n);
    end
    v4_valid = 1'b0;
    v8_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_out_valid", int'(o4_valid), 0);
    check("reset_out_sum", int'(o4_sum), 0);
    check("reset_out_ovf", int'(o4_ovf), 0);
    check("reset_in_ready", int'(v4_ready), 1);
    @(posedge clk);
    #1;

    // Basic word: 1 + 6 + 49 + 20 = 76
    q4.push_back('{sum: 8'd76, ovf: 1'b0});
    send(0, 1, 1); send(0, 2, 3); send(0, 7, 7); send(0, 5, 4);
    check("latency_out_valid", int'(o4_valid), 1);
    check("latency_in_ready", int'(v4_ready), 0);

    // Every single product through an otherwise zero word
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        q4.push_back('{sum: 8'(a * b), ovf: 1'b0});
        send(0, a, b); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
      end
    end

    // Backpressure: 2 + 12 + 30 + 7 = 51, stalled for 5 cycles
    q4.push_back('{sum: 8'd51, ovf: 1'b0});
    send(0, 1, 2); send(0, 3, 4); send(0, 5, 6);
    o4_ready = 1'b0;
    send(0, 7, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", int'(v4_ready), 0);
      check("stall_out_valid", int'(o4_valid), 1);
      check("stall_out_sum", int'(o4_sum), 51);
      @(posedge clk);
      #1;
    end
    o4_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", int'(v4_ready), 1);
    check("release_out_valid", int'(o4_valid), 0);

    // Overflow on the 8-term instance: eight 7*7 products = 392
    q8.push_back('{sum: OVF_SUM, ovf: 1'b1});
    for (int i = 0; i < 8; i++) send(1, 7, 7);

    // Clear discards the partial sum and the same-cycle pair
    send(0, 7, 7); send(0, 3, 3);
    v4_valid = 1'b1; v4_a = 3'd2; v4_b = 3'd2; v4_clear = 1'b1;
    @(posedge clk);
    #1;
    v4_valid = 1'b0; v4_clear = 1'b0;
    q4.push_back('{sum: 8'd4, ovf: 1'b0});
    for (int i = 0; i < 4; i++) send(0, 1, 1);
    @(posedge clk);
    #1;
    check("post_clear_hold_sum", int'(o4_sum), 4);

    // Asynchronous reset mid-word
    send(0, 1, 1); send(0, 2, 2);
    rst = 1'b1;
    #1;
    check("midrst_out_sum", int'(o4_sum), 0);
    check("midrst_out_valid", int'(o4_valid), 0);
    check("midrst_out_ovf", int'(o4_ovf), 0);
    check("midrst_in_ready", int'(v4_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    q4.push_back('{sum: 8'd24, ovf: 1'b0});
    for (int i = 0; i < 4; i++) send(0, 2, 3);

    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q4.size() != 0 || q8.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL drain_timeout got %0d+%0d words outstanding, expected 0", q4.size(), q8.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
